vn_output_collector: RTL and testbench
======================================

# vn_output_collector

Downstream stage for one edge adder switch. It captures the switch's registered VN outputs (`o_vn` / `o_vn_valid`, 0–2 results per cycle) into a first-word-fall-through FIFO and drains them one word per cycle to the output writeback path with a valid/ready handshake. The adder switch cannot be stalled, so overflow is handled by flagged dropping: excess results are discarded and counted, never silently lost.

## Interface
Parameters:
- `DATA_TYPE`, 32, width of one VN result word.
- `DEPTH`, 16, FIFO entries; must be a power of 2 and ≥ 4.
- `AFULL_THRESH`, 14, `o_almost_full` asserts when occupancy ≥ this value.
- Derived: `CNT_W` = log2(`DEPTH`)+1.

Ports:
- `clk`, input, 1, single clock; all logic is on the rising edge.
- `rst`, input, 1, **synchronous, active-low** reset (reset when `rst`==0).
- `i_vn`, input, 2*`DATA_TYPE`, VN results. Lane0 = [`DATA_TYPE`-1:0]; lane1 = [2*`DATA_TYPE`-1:`DATA_TYPE`].
- `i_vn_valid`, input, 2, per-lane valid. Bit0 = lane0, bit1 = lane1.
- `i_clear`, input, 1, synchronous soft clear.
- `i_ready`, input, 1, downstream ready.
- `o_data`, output, `DATA_TYPE`, head-of-FIFO word.
- `o_valid`, output, 1, `o_data` is valid.
- `o_count`, output, `CNT_W`, current occupancy.
- `o_almost_full`, output, 1, asserted while `o_count` ≥ `AFULL_THRESH`.
- `o_overflow`, output, 1, sticky; set when any lane is dropped.
- `o_drop_cnt`, output, 16, number of dropped words; saturates at 65535.

## Operation
- Read event: `rd` = `o_valid` && `i_ready`. Pops one entry.
- Write request: `n_w` = popcount(`i_vn_valid`), range 0–2.
- Available space: `space` = `DEPTH` − `count` + `rd`. A read in the same cycle frees its slot for that cycle's writes.
- Accept rules:
  - If `n_w` ≤ `space`, write all requested lanes.
  - If `n_w`=2 and `space`=1, write lane0 and drop lane1.
  - If `space`=0, drop every requested lane.
- Write order: lane0 is written before lane1 (lane0 at `wr_ptr`, lane1 at `wr_ptr`+1). If only lane1 is valid, it goes to `wr_ptr`.
- Count update: `count` ← `count` + accepted − `rd`.
- Pointer wrap: `wr_ptr` and `rd_ptr` wrap modulo `DEPTH`.
- On a drop: `o_overflow` ← 1 and `o_drop_cnt` += dropped count (1 or 2), saturating at 65535.
- Output: `o_valid` = (`count` ≠ 0). `o_data` = mem[`rd_ptr`] when valid, otherwise 0.
- `o_data` must stay stable while `o_valid`=1 and `i_ready`=0.
- No empty bypass: a word written into an empty FIFO is not readable in the same cycle.
- `i_clear` (when `rst`=1):
  - Sets pointers, `count`, `o_overflow` and `o_drop_cnt` to 0.
  - Discards that cycle's writes; suppresses that cycle's read.
  - Does not count discarded inputs as drops.
- Priority: `rst` > `i_clear` > normal operation.

## Timing
- Reset values (edge where `rst`=0): `o_valid`=0, `o_data`=0, `o_count`=0, `o_almost_full`=0, `o_overflow`=0, `o_drop_cnt`=0; pointers = 0. Memory contents need not be reset.
- Reset mid-operation: all stored words are lost. Outputs take their reset values after that edge. Inputs present in the reset cycle are ignored.
- Write latency: a lane valid at edge N appears at `o_data` with `o_valid`=1 in the cycle after edge N, provided it is at the FIFO head.
- Sustained throughput: 1 read per cycle. Writes burst up to 2 per cycle.
- `o_count`, `o_almost_full`, `o_overflow` and `o_drop_cnt` all reflect state after the most recent edge; none has a combinational input path.
- Full with simultaneous read: when `count`=`DEPTH`, `rd`=1 and `n_w`=1, the word is accepted, no drop occurs, and `count` stays at `DEPTH`.

## Test plan
- Reset, then drive `i_vn_valid`=2'b11 with lane0=0x11, lane1=0x22 and `i_ready`=1 → `o_data` shows 0x11 then 0x22 on consecutive cycles; `o_count` goes 2 → 1 → 0; no drops.
- Drive `i_vn_valid`=2'b10 with lane1=0xAB into an empty FIFO → next cycle `o_valid`=1, `o_data`=0xAB; lane0 is ignored.
- Hold `i_ready`=0 and write 2 words per cycle for 8 cycles (`DEPTH`=16) → `o_count`=16 and `o_almost_full` from count 14. Then one more 2'b11 write → `o_overflow`=1, `o_drop_cnt`=2, and `o_data` remains the first word.
- Full FIFO with `i_ready`=1 and `i_vn_valid`=2'b11 → lane0 accepted, lane1 dropped; `o_drop_cnt` += 1; `o_count` stays 16.
- Fill 10 entries with overflow set, then pulse `i_clear` concurrently with a 2'b11 write → next cycle `o_valid`=0, `o_count`=0, `o_overflow`=0, `o_drop_cnt`=0.
- Stream 40 words with random `i_ready` and random `i_vn_valid` → output order matches a scoreboard (lane0 before lane1, pointers wrap cleanly), and `o_data` is stable during stalls. Then assert `rst`=0 mid-stream → all outputs 0 on the next cycle.

Source files
------------

// File: rtl/vn_output_collector.sv
// vn_output_collector
// Captures up to two VN results per cycle from an edge adder switch into a
// first-word-fall-through FIFO, and drains one word per cycle downstream.
// The switch cannot be stalled. Excess results are dropped, and each drop is
// counted and flagged.
module vn_output_collector #(
  parameter int DATA_TYPE    = 32,
  parameter int DEPTH        = 16,
  parameter int AFULL_THRESH = 14,
  localparam int CNT_W       = $clog2(DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [2*DATA_TYPE-1:0] i_vn,
  input  logic [1:0]             i_vn_valid,
  input  logic                   i_clear,
  input  logic                   i_ready,
  output logic [DATA_TYPE-1:0]   o_data,
  output logic                   o_valid,
  output logic [CNT_W-1:0]       o_count,
  output logic                   o_almost_full,
  output logic                   o_overflow,
  output logic [15:0]            o_drop_cnt
);

  localparam int PTR_W = CNT_W - 1;

  logic [DATA_TYPE-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic [15:0]      drop_cnt_q, drop_cnt_d;

  logic                 rd;
  logic [1:0]           n_w;
  logic [CNT_W-1:0]     space;
  logic [1:0]           acc;
  logic [1:0]           drop;
  logic                 we0, we1;
  logic [PTR_W-1:0]     wr_ptr_p1;
  logic [DATA_TYPE-1:0] wd0, wd1;
  logic [16:0]          drop_sum;

  // Decide how many lanes fit, then compute the next pointer, count and drop state.
  always_comb begin
    rd        = (count_q != '0) && i_ready && !i_clear;
    n_w       = {1'b0, i_vn_valid[0]} + {1'b0, i_vn_valid[1]};
    // A read in this cycle frees its slot for this cycle's writes.
    space     = CNT_W'(DEPTH) - count_q + CNT_W'(rd);
    acc       = 2'd0;
    if (CNT_W'(n_w) <= space)      acc = n_w;
    else if (space == CNT_W'(1))   acc = 2'd1;
    drop      = n_w - acc;
    // Lane0 goes first. A lone lane1 takes the lane0 slot.
    wd0       = i_vn_valid[0] ? i_vn[DATA_TYPE-1:0] : i_vn[2*DATA_TYPE-1:DATA_TYPE];
    wd1       = i_vn[2*DATA_TYPE-1:DATA_TYPE];
    we0       = rst && !i_clear && (acc != 2'd0);
    we1       = rst && !i_clear && (acc == 2'd2);
    wr_ptr_p1 = wr_ptr_q + PTR_W'(1);
    drop_sum  = {1'b0, drop_cnt_q} + 17'(drop);

    wr_ptr_d   = wr_ptr_q + PTR_W'(acc);
    rd_ptr_d   = rd_ptr_q + PTR_W'(rd);
    count_d    = count_q + CNT_W'(acc) - CNT_W'(rd);
    overflow_d = overflow_q | (drop != 2'd0);
    drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];

    // A soft clear discards this cycle's traffic without counting it as dropped.
    if (i_clear) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end
  end

  // Control state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Storage writes. The contents are not reset, because count gates visibility.
  always_ff @(posedge clk) begin
    if (we0) mem_q[wr_ptr_q]  <= wd0;
    if (we1) mem_q[wr_ptr_p1] <= wd1;
  end

  assign o_valid       = (count_q != '0);
  assign o_data        = o_valid ? mem_q[rd_ptr_q] : '0;
  assign o_count       = count_q;
  assign o_almost_full = (count_q >= CNT_W'(AFULL_THRESH));
  assign o_overflow    = overflow_q;
  assign o_drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_vn_output_collector.sv
// Scoreboard bench for vn_output_collector. The driver pushes the words the
// FIFO should accept. The monitor pops them when a read handshake occurs.
module tb_vn_output_collector;

  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int AF    = 14;

  logic          clk = 1'b0;
  logic          rst;
  logic [2*DW-1:0] i_vn;
  logic [1:0]    i_vn_valid;
  logic          i_clear;
  logic          i_ready;
  logic [DW-1:0] o_data;
  logic          o_valid;
  logic [4:0]    o_count;
  logic          o_almost_full;
  logic          o_overflow;
  logic [15:0]   o_drop_cnt;

  vn_output_collector #(.DATA_TYPE(DW), .DEPTH(DEPTH), .AFULL_THRESH(AF)) dut (
    .clk(clk), .rst(rst), .i_vn(i_vn), .i_vn_valid(i_vn_valid),
    .i_clear(i_clear), .i_ready(i_ready), .o_data(o_data), .o_valid(o_valid),
    .o_count(o_count), .o_almost_full(o_almost_full), .o_overflow(o_overflow),
    .o_drop_cnt(o_drop_cnt)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_bad = 0;
  logic [DW-1:0] exp_q [$];
  int          m_cnt = 0;
  logic        m_ovf = 1'b0;
  int          m_drop = 0;
  logic        prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle. Drive the inputs, advance the model, and push accepted words.
  // After the edge, check the registered status outputs against the model.
  task automatic cycle(input logic [1:0] v, input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                       input logic rdy, input logic clr, input logic rstn);
    int n, sp, acc, rdm;
    rst = rstn; i_clear = clr; i_ready = rdy; i_vn_valid = v; i_vn = {d1, d0};
    if (!rstn || clr) begin
      exp_q.delete(); m_cnt = 0; m_ovf = 1'b0; m_drop = 0;
    end else begin
      rdm = (m_cnt != 0 && rdy) ? 1 : 0;
      n   = int'(v[0]) + int'(v[1]);
      sp  = DEPTH - m_cnt + rdm;
      if (n <= sp) acc = n;
      else if (sp == 1) acc = 1;
      else acc = 0;
      if (acc >= 1) exp_q.push_back(v[0] ? d0 : d1);
      if (acc == 2) exp_q.push_back(d1);
      if (n > acc) begin
        m_ovf  = 1'b1;
        m_drop = (m_drop + n - acc > 65535) ? 65535 : m_drop + n - acc;
      end
      m_cnt = m_cnt + acc - rdm;
    end
    @(posedge clk); #1;
    chk("count", DW'(o_count), DW'(m_cnt));
    chk("valid", DW'(o_valid), DW'(m_cnt != 0));
    chk("almost_full", DW'(o_almost_full), DW'(m_cnt >= AF));
    chk("overflow", DW'(o_overflow), DW'(m_ovf));
    chk("drop_cnt", DW'(o_drop_cnt), DW'(m_drop));
    if (m_cnt == 0) chk("data_zero", o_data, '0);
  endtask

  // Monitor: on each read handshake, compare o_data with the scoreboard head.
  // Across a stall, also require o_data to hold its value.
  always @(negedge clk) begin
    if (rst && !i_clear) begin
      if (prev_stall && o_valid) chk("stall_stable", o_data, prev_data);
      if (o_valid && i_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL pop_empty: got %h expected none", o_data);
        end else begin
          chk("data_order", o_data, exp_q.pop_front());
        end
      end
    end
    prev_stall = rst && !i_clear && o_valid && !i_ready;
    prev_data  = o_data;
  end

  initial begin
    int sent;
    logic [1:0] v;
    rst = 1'b0; i_clear = 1'b0; i_ready = 1'b0; i_vn_valid = '0; i_vn = '0;

    // Reset
    cycle(2'b00, 0, 0, 1'b0, 1'b0, 1'b0);
    cycle(2'b11, 32'hDEAD, 32'hBEEF, 1'b1, 1'b0, 1'b0);

    // Write two lanes, then drain them in order.
    cycle(2'b11, 32'h11, 32'h22, 1'b1, 1'b0, 1'b1);
    chk("first_word", o_data, 32'h11);
    cycle(2'b00, 0, 0, 1'b1, 1'b0, 1'b1);
    chk("second_word", o_data, 32'h22);
    cycle(2'b00, 0, 0, 1'b1, 1'b0, 1'b1);

    // A lone lane1 write goes into the head slot.
    cycle(2'b10, 32'h55, 32'hAB, 1'b1, 1'b0, 1'b1);
    chk("lane1_only", o_data, 32'hAB);
    cycle(2'b00, 0, 0, 1'b1, 1'b0, 1'b1);

    // Fill to full while the output is stalled, then overflow by two words.
    for (int i = 0; i < 8; i++)
      cycle(2'b11, 32'h100 + 2*i, 32'h101 + 2*i, 1'b0, 1'b0, 1'b1);
    chk("full_count", DW'(o_count), 32'd16);
    cycle(2'b11, 32'h200, 32'h201, 1'b0, 1'b0, 1'b1);
    chk("ovf_drop2", DW'(o_drop_cnt), 32'd2);
    chk("head_kept", o_data, 32'h100);

    // When full with a simultaneous read, lane0 is accepted and lane1 is dropped.
    cycle(2'b11, 32'h300, 32'h301, 1'b1, 1'b0, 1'b1);
    chk("full_rd_drop", DW'(o_drop_cnt), 32'd3);
    chk("full_rd_count", DW'(o_count), 32'd16);

    // Drain to 10 entries, then clear while writing.
    for (int i = 0; i < 6; i++) cycle(2'b00, 0, 0, 1'b1, 1'b0, 1'b1);
    chk("ten_left", DW'(o_count), 32'd10);
    cycle(2'b11, 32'h400, 32'h401, 1'b1, 1'b1, 1'b1);
    chk("clr_valid", DW'(o_valid), 32'd0);
    chk("clr_drop", DW'(o_drop_cnt), 32'd0);
    cycle(2'b00, 0, 0, 1'b1, 1'b0, 1'b1);

    // Random stream of 40 words with random ready.
    sent = 0;
    while (sent < 40) begin
      v = 2'($urandom_range(0, 3));
      cycle(v, 32'h1000 + sent, 32'h1000 + sent + 1, 1'($urandom_range(0, 1)), 1'b0, 1'b1);
      sent += 2;
    end
    // Reset in the middle of the stream.
    cycle(2'b11, 32'h9000, 32'h9001, 1'b1, 1'b0, 1'b0);
    chk("rst_mid_data", o_data, '0);
    chk("rst_mid_ovf", DW'(o_overflow), 32'd0);
    // Recovery after the reset.
    cycle(2'b01, 32'hA0, 32'hA1, 1'b1, 1'b0, 1'b1);
    chk("post_rst_word", o_data, 32'hA0);
    cycle(2'b00, 0, 0, 1'b1, 1'b0, 1'b1);
    cycle(2'b00, 0, 0, 1'b1, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
